// File: rtl/gpr_read_sequencer_pkg.sv
// Shared types and constants for the GPR read-port sequencer.
// Operand slots are indexed rs1=0, rs2=1, rs3=2 throughout.
package gpr_read_sequencer_pkg;

  localparam int NUM_SRC_OPS = 3;

  typedef logic [1:0] op_idx_t;

  localparam op_idx_t OP_RS1 = 2'd0;
  localparam op_idx_t OP_RS2 = 2'd1;
  localparam op_idx_t OP_RS3 = 2'd2;

  typedef logic [1:0] gpr_seq_state_e;

  localparam gpr_seq_state_e ST_IDLE  = 2'd0;
  localparam gpr_seq_state_e ST_RD    = 2'd1;
  localparam gpr_seq_state_e ST_WAIT  = 2'd2;
  localparam gpr_seq_state_e ST_VALID = 2'd3;

  // Lowest pending operand wins, which gives rs1 -> rs2 -> rs3 issue order.
  function automatic op_idx_t first_set_idx(input logic [NUM_SRC_OPS-1:0] mask);
    op_idx_t idx;
    idx = OP_RS1;
    if (mask[OP_RS1]) begin
      idx = OP_RS1;
    end else if (mask[OP_RS2]) begin
      idx = OP_RS2;
    end else if (mask[OP_RS3]) begin
      idx = OP_RS3;
    end
    return idx;
  endfunction

endpackage

// File: rtl/gpr_read_sequencer_operand_capture.sv
// One operand slot: remembers any writeback that raced its read and merges
// it lane-by-lane over the RAM data when the read returns.
module gpr_operand_capture #(
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int ADDRW       = 7
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        issue_en,
  input  logic [ADDRW-1:0]            rd_addr,
  input  logic                        wb_valid,
  input  logic [ADDRW-1:0]            wb_addr,
  input  logic [NUM_THREADS-1:0]      wb_tmask,
  input  logic [NUM_THREADS*XLEN-1:0] wb_data,
  input  logic                        capture_en,
  input  logic [NUM_THREADS*XLEN-1:0] rd_data,
  output logic [NUM_THREADS*XLEN-1:0] operand
);

  logic [NUM_THREADS-1:0]      byp_mask_q;
  logic [NUM_THREADS*XLEN-1:0] byp_data_q;
  logic [NUM_THREADS*XLEN-1:0] merged;
  logic                        wb_hit;

  assign wb_hit = wb_valid && (wb_addr == rd_addr);

  always_comb begin
    merged = rd_data;
    for (int l = 0; l < NUM_THREADS; l++) begin
      if (byp_mask_q[l]) begin
        merged[l*XLEN +: XLEN] = byp_data_q[l*XLEN +: XLEN];
      end
    end
  end

  // The RAM has no read/write collision check, so a same-cycle write is caught here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byp_mask_q <= '0;
      byp_data_q <= '0;
      operand    <= '0;
    end else begin
      if (issue_en) begin
        byp_mask_q <= wb_hit ? wb_tmask : '0;
        byp_data_q <= wb_data;
      end
      if (clear) begin
        operand <= '0;
      end else if (capture_en) begin
        operand <= merged;
      end
    end
  end

endmodule

// File: rtl/gpr_read_sequencer.sv
// Serialises up to three operand reads of one instruction over a single GPR
// read port and presents all operands together downstream.
module gpr_read_sequencer
  import gpr_read_sequencer_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int ADDRW       = 7,
  parameter int TAGW        = 64
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    req_valid,
  output logic                                    req_ready,
  input  logic [NUM_SRC_OPS-1:0]                  req_use,
  input  logic [NUM_SRC_OPS*ADDRW-1:0]            req_addr,
  input  logic [TAGW-1:0]                         req_tag,
  output logic                                    gpr_rd_en,
  output logic [ADDRW-1:0]                        gpr_rd_addr,
  input  logic [NUM_THREADS*XLEN-1:0]             gpr_rd_data,
  input  logic                                    wb_valid,
  input  logic [ADDRW-1:0]                        wb_addr,
  input  logic [NUM_THREADS-1:0]                  wb_tmask,
  input  logic [NUM_THREADS*XLEN-1:0]             wb_data,
  output logic                                    rsp_valid,
  input  logic                                    rsp_ready,
  output logic [TAGW-1:0]                         rsp_tag,
  output logic [NUM_SRC_OPS*NUM_THREADS*XLEN-1:0] rsp_data
);

  localparam int DATAW = NUM_THREADS * XLEN;

  gpr_seq_state_e         state_q;
  gpr_seq_state_e         state_d;
  logic [NUM_SRC_OPS-1:0] use_rem_q;
  logic [NUM_SRC_OPS-1:0] use_rem_left;
  logic [ADDRW-1:0]       addr_q [NUM_SRC_OPS];
  logic [TAGW-1:0]        tag_q;
  logic                   cap_valid_q;
  op_idx_t                cap_idx_q;
  op_idx_t                issue_idx;
  logic                   issue_fire;
  logic                   accept;
  logic [ADDRW-1:0]       issue_addr;
  logic [DATAW-1:0]       operand [NUM_SRC_OPS];

  assign req_ready  = (state_q == ST_IDLE) || ((state_q == ST_VALID) && rsp_ready);
  assign accept     = req_valid && req_ready;
  assign issue_fire = (state_q == ST_RD);
  assign issue_idx  = first_set_idx(use_rem_q);

  always_comb begin
    use_rem_left            = use_rem_q;
    use_rem_left[issue_idx] = 1'b0;
  end

  always_comb begin
    case (issue_idx)
      OP_RS2:  issue_addr = addr_q[OP_RS2];
      OP_RS3:  issue_addr = addr_q[OP_RS3];
      default: issue_addr = addr_q[OP_RS1];
    endcase
  end

  assign gpr_rd_en   = issue_fire;
  assign gpr_rd_addr = issue_fire ? issue_addr : '0;

  // Accepting from VALID re-enters directly, so back-to-back requests need no idle gap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_VALID: begin
        if (accept) begin
          state_d = (req_use == '0) ? ST_VALID : ST_RD;
        end else if ((state_q == ST_VALID) && rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        if (use_rem_left == '0) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT:  state_d = ST_VALID;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Capture lags issue by one cycle, so the slot being read is piped alongside.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      use_rem_q   <= '0;
      tag_q       <= '0;
      cap_valid_q <= 1'b0;
      cap_idx_q   <= OP_RS1;
      for (int i = 0; i < NUM_SRC_OPS; i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cap_valid_q <= issue_fire;
      cap_idx_q   <= issue_idx;
      if (accept) begin
        use_rem_q <= req_use;
        tag_q     <= req_tag;
        for (int i = 0; i < NUM_SRC_OPS; i++) begin
          addr_q[i] <= req_addr[i*ADDRW +: ADDRW];
        end
      end else if (issue_fire) begin
        use_rem_q <= use_rem_left;
      end
    end
  end

  for (genvar g = 0; g < NUM_SRC_OPS; g++) begin : g_op
    gpr_operand_capture #(
      .NUM_THREADS (NUM_THREADS),
      .XLEN        (XLEN),
      .ADDRW       (ADDRW)
    ) u_capture (
      .clk        (clk),
      .reset      (reset),
      .clear      (accept),
      .issue_en   (issue_fire && (issue_idx == op_idx_t'(g))),
      .rd_addr    (gpr_rd_addr),
      .wb_valid   (wb_valid),
      .wb_addr    (wb_addr),
      .wb_tmask   (wb_tmask),
      .wb_data    (wb_data),
      .capture_en (cap_valid_q && (cap_idx_q == op_idx_t'(g))),
      .rd_data    (gpr_rd_data),
      .operand    (operand[g])
    );
  end

  assign rsp_valid = (state_q == ST_VALID);
  assign rsp_tag   = tag_q;
  assign rsp_data  = {operand[OP_RS3], operand[OP_RS2], operand[OP_RS1]};

endmodule

// File: tb/tb_gpr_read_sequencer.sv
// Directed bench for gpr_read_sequencer with a behavioural 1-cycle-latency
// GPR RAM that returns pre-write data on a same-cycle read/write.
module tb_gpr_read_sequencer;

  localparam int CW = 384;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [2:0]   req_use = '0;
  logic [20:0]  req_addr = '0;
  logic [63:0]  req_tag = '0;
  logic         gpr_rd_en;
  logic [6:0]   gpr_rd_addr;
  logic [127:0] gpr_rd_data = '0;
  logic         wb_valid = 1'b0;
  logic [6:0]   wb_addr = '0;
  logic [3:0]   wb_tmask = '0;
  logic [127:0] wb_data = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [63:0]  rsp_tag;
  logic [383:0] rsp_data;

  int tests_run = 0;
  int tests_failed = 0;

  logic [127:0] mem [128];

  gpr_read_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_use     (req_use),
    .req_addr    (req_addr),
    .req_tag     (req_tag),
    .gpr_rd_en   (gpr_rd_en),
    .gpr_rd_addr (gpr_rd_addr),
    .gpr_rd_data (gpr_rd_data),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_tmask    (wb_tmask),
    .wb_data     (wb_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_tag     (rsp_tag),
    .rsp_data    (rsp_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (gpr_rd_en) gpr_rd_data <= mem[gpr_rd_addr];
    if (wb_valid) begin
      for (int l = 0; l < 4; l++) begin
        if (wb_tmask[l]) mem[wb_addr][l*32 +: 32] <= wb_data[l*32 +: 32];
      end
    end
  end

  function automatic logic [127:0] lanes(input logic [31:0] v);
    return {4{v}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] u, input logic [20:0] a,
                               input logic [63:0] t);
    req_valid = v;
    req_use   = u;
    req_addr  = a;
    req_tag   = t;
  endtask

  task automatic checkOutput(input string name, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  localparam logic [20:0] ADDR_123 = {7'd3, 7'd2, 7'd1};

  initial begin
    // Preload addresses 1..3 through the writeback port while the DUT is held in reset.
    wb_valid = 1'b1;
    wb_tmask = 4'hF;
    wb_addr = 7'd1; wb_data = lanes(32'h11); tick();
    wb_addr = 7'd2; wb_data = lanes(32'h22); tick();
    wb_addr = 7'd3; wb_data = lanes(32'h33); tick();
    wb_valid = 1'b0;

    checkOutput("rst_req_ready", CW'(req_ready), CW'(1'b1));
    checkOutput("rst_rsp_valid", CW'(rsp_valid), CW'(1'b0));
    checkOutput("rst_rd_en",     CW'(gpr_rd_en), CW'(1'b0));
    checkOutput("rst_rd_addr",   CW'(gpr_rd_addr), CW'(7'd0));
    checkOutput("rst_tag",       CW'(rsp_tag), CW'(64'd0));
    checkOutput("rst_data",      rsp_data, '0);
    reset = 1'b0;
    tick();

    // All three operands.
    applyStimulus(1'b1, 3'b111, ADDR_123, 64'h1111);
    tick();
    applyStimulus(1'b0, 3'b000, '0, '0);
    checkOutput("t1_c1_en",    CW'(gpr_rd_en), CW'(1'b1));
    checkOutput("t1_c1_addr",  CW'(gpr_rd_addr), CW'(7'd1));
    checkOutput("t1_c1_ready", CW'(req_ready), CW'(1'b0));
    tick();
    checkOutput("t1_c2_addr",  CW'(gpr_rd_addr), CW'(7'd2));
    tick();
    checkOutput("t1_c3_addr",  CW'(gpr_rd_addr), CW'(7'd3));
    tick();
    checkOutput("t1_c4_en",    CW'(gpr_rd_en), CW'(1'b0));
    checkOutput("t1_c4_valid", CW'(rsp_valid), CW'(1'b0));
    tick();
    checkOutput("t1_c5_valid", CW'(rsp_valid), CW'(1'b1));
    checkOutput("t1_c5_data",  rsp_data, {lanes(32'h33), lanes(32'h22), lanes(32'h11)});
    checkOutput("t1_c5_tag",   CW'(rsp_tag), CW'(64'h1111));
    checkOutput("t1_c5_ready", CW'(req_ready), CW'(1'b1));
    tick();
    checkOutput("t1_idle_valid", CW'(rsp_valid), CW'(1'b0));

    // rs1 and rs3 only.
    applyStimulus(1'b1, 3'b101, ADDR_123, 64'h2222);
    tick();
    applyStimulus(1'b0, 3'b000, '0, '0);
    checkOutput("t2_c1_addr",  CW'(gpr_rd_addr), CW'(7'd1));
    tick();
    checkOutput("t2_c2_en",    CW'(gpr_rd_en), CW'(1'b1));
    checkOutput("t2_c2_addr",  CW'(gpr_rd_addr), CW'(7'd3));
    tick();
    checkOutput("t2_c3_en",    CW'(gpr_rd_en), CW'(1'b0));
    checkOutput("t2_c3_valid", CW'(rsp_valid), CW'(1'b0));
    tick();
    checkOutput("t2_c4_valid", CW'(rsp_valid), CW'(1'b1));
    checkOutput("t2_c4_data",  rsp_data, {lanes(32'h33), 128'd0, lanes(32'h11)});
    tick();

    // No operands.
    applyStimulus(1'b1, 3'b000, ADDR_123, 64'hABCD);
    tick();
    applyStimulus(1'b0, 3'b000, '0, '0);
    checkOutput("t3_c1_valid", CW'(rsp_valid), CW'(1'b1));
    checkOutput("t3_c1_en",    CW'(gpr_rd_en), CW'(1'b0));
    checkOutput("t3_c1_data",  rsp_data, '0);
    checkOutput("t3_c1_tag",   CW'(rsp_tag), CW'(64'hABCD));
    tick();

    // Writeback racing the rs2 read.
    applyStimulus(1'b1, 3'b111, ADDR_123, 64'h4444);
    tick();
    applyStimulus(1'b0, 3'b000, '0, '0);
    tick();
    checkOutput("t4_c2_addr", CW'(gpr_rd_addr), CW'(7'd2));
    wb_valid = 1'b1; wb_addr = 7'd2; wb_tmask = 4'b0101; wb_data = lanes(32'hDEAD);
    tick();
    wb_valid = 1'b0;
    tick();
    tick();
    checkOutput("t4_c5_valid", CW'(rsp_valid), CW'(1'b1));
    checkOutput("t4_c5_data", rsp_data,
                {lanes(32'h33), {32'h22, 32'hDEAD, 32'h22, 32'hDEAD}, lanes(32'h11)});
    tick();
    wb_valid = 1'b1; wb_addr = 7'd2; wb_tmask = 4'hF; wb_data = lanes(32'h22);
    tick();
    wb_valid = 1'b0;

    // Downstream stall, then back-to-back accepts.
    rsp_ready = 1'b0;
    applyStimulus(1'b1, 3'b011, ADDR_123, 64'h5555);
    tick();
    applyStimulus(1'b0, 3'b000, '0, '0);
    tick(); tick(); tick();
    checkOutput("t5_c4_valid", CW'(rsp_valid), CW'(1'b1));
    applyStimulus(1'b1, 3'b111, ADDR_123, 64'h6666);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("t5_stall_valid", CW'(rsp_valid), CW'(1'b1));
      checkOutput("t5_stall_data",  rsp_data, {128'd0, lanes(32'h22), lanes(32'h11)});
      checkOutput("t5_stall_tag",   CW'(rsp_tag), CW'(64'h5555));
      checkOutput("t5_stall_ready", CW'(req_ready), CW'(1'b0));
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("t5_fire_ready", CW'(req_ready), CW'(1'b1));
    tick();
    applyStimulus(1'b0, 3'b000, '0, '0);
    checkOutput("t6_c1_valid", CW'(rsp_valid), CW'(1'b0));
    checkOutput("t6_c1_addr",  CW'(gpr_rd_addr), CW'(7'd1));
    tick(); tick(); tick(); tick();
    checkOutput("t6_c5_valid", CW'(rsp_valid), CW'(1'b1));
    checkOutput("t6_c5_data",  rsp_data, {lanes(32'h33), lanes(32'h22), lanes(32'h11)});
    checkOutput("t6_c5_tag",   CW'(rsp_tag), CW'(64'h6666));
    applyStimulus(1'b1, 3'b000, ADDR_123, 64'h7777);
    tick();
    applyStimulus(1'b0, 3'b000, '0, '0);
    checkOutput("t6_b2b_valid", CW'(rsp_valid), CW'(1'b1));
    checkOutput("t6_b2b_tag",   CW'(rsp_tag), CW'(64'h7777));
    checkOutput("t6_b2b_data",  rsp_data, '0);
    tick();
    checkOutput("t6_idle_valid", CW'(rsp_valid), CW'(1'b0));
    checkOutput("t6_idle_ready", CW'(req_ready), CW'(1'b1));

    // Reset during the second read cycle.
    applyStimulus(1'b1, 3'b111, ADDR_123, 64'h8888);
    tick();
    applyStimulus(1'b0, 3'b000, '0, '0);
    tick();
    checkOutput("t7_c2_en", CW'(gpr_rd_en), CW'(1'b1));
    reset = 1'b1;
    tick();
    checkOutput("t7_rst_valid", CW'(rsp_valid), CW'(1'b0));
    checkOutput("t7_rst_en",    CW'(gpr_rd_en), CW'(1'b0));
    checkOutput("t7_rst_ready", CW'(req_ready), CW'(1'b1));
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("t7_no_rsp", CW'(rsp_valid), CW'(1'b0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
